display_arbiter: RTL and testbench

Shares the four-digit seven-segment display between the four services and sequences the digit scan. Each service raises a request and presents a 16-bit BCD number plus a per-digit blink mask. The arbiter grants exactly one owner at a time, or shows the idle number (current time) when no service owns the display. It drives one-hot digit enables and a decoded segment pattern, one digit per scan slot, blanking digits whose blink bit is set during the off phase.

---
 rtl/display_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_display_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - four-service seven-segment display arbiter with digit scan and blink
//
// Purpose: grants the shared 4-digit display to one service at a time and shows
// idle_num when no service owns it. A one-cycle blank GAP separates every change
// of owner. The block scans one digit per slot and blanks masked digits during
// the off phase of the blink cycle.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous reset, active-high despite the name
//   req[3:0]   service requests (bit3 = svc1, bit2 = svc2, bit1 = svc3, bit0 = svc4)
//   num_bus    BCD numbers, 16 bits per service, same bit ordering as req
//   blink_bus  per-digit blink masks, 4 bits per service, bit3 = leftmost digit
//   idle_num   BCD number shown while idle
//   grant      one-hot owner (registered), 0 in IDLE/GAP
//   an         one-hot digit enable (registered), an[3] = leftmost digit
//   seg        segments {g,f,e,d,c,b,a} (registered), active-high
module display_arbiter #(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_HALF = 250
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [63:0] num_bus,
  input  logic [15:0] blink_bus,
  input  logic [15:0] idle_num,
  output logic [3:0]  grant,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_OWN  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_owner, w_owner_nxt;   // req bit index: pending owner in GAP, owner in OWN
  logic            r_pend,  w_pend_nxt;    // GAP has a valid pending owner
  logic [SW-1:0]   r_slot,  w_slot_nxt;
  logic [1:0]      r_digit, w_digit_nxt;
  logic [FW-1:0]   r_frame, w_frame_nxt;
  logic            r_phase, w_phase_nxt;   // 1 = blink phase on (digits visible)
  logic [3:0]      r_grant, w_grant_nxt;
  logic [3:0]      r_an,    w_an_nxt;
  logic [6:0]      r_seg,   w_seg_nxt;
  logic            w_slot_wrap;
  logic            w_frame_adv;
  logic            w_enter_own;
  logic [15:0]     w_src;
  logic [3:0]      w_nib;

  // Service 4 (bit0) wins, then services 1, 2, 3.
  function automatic logic [1:0] f_pick(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[3]) return 2'd3;
    else if (r[2]) return 2'd2;
    else           return 2'd1;
  endfunction

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= S_IDLE;
      r_owner <= 2'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_pend_nxt  = r_pend;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_GAP;
          w_owner_nxt = f_pick(req);
          w_pend_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        // The pending owner must still be requesting, otherwise fall back to idle.
        if (r_pend && req[r_owner]) begin
          w_state_nxt = S_OWN;
        end else begin
          w_state_nxt = S_IDLE;
          w_pend_nxt  = 1'b0;
        end
      end
      S_OWN: begin
        if (!req[r_owner]) begin
          // Release: next owner is the best remaining request, if any.
          w_state_nxt = S_GAP;
          w_owner_nxt = f_pick(req);
          w_pend_nxt  = |req;
        end else if (r_owner != 2'd0 && req[0]) begin
          // Only service 4 may preempt.
          w_state_nxt = S_GAP;
          w_owner_nxt = 2'd0;
          w_pend_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  // Scan and blink counters
  always_comb begin
    w_slot_wrap = (r_slot == SLOT_LAST);
    w_slot_nxt  = w_slot_wrap ? '0 : r_slot + SW'(1);
    w_digit_nxt = w_slot_wrap ? r_digit - 2'd1 : r_digit;
    w_frame_adv = w_slot_wrap && (r_digit == 2'd0);
    w_enter_own = (w_state_nxt == S_OWN) && (r_state != S_OWN);
    w_frame_nxt = r_frame;
    w_phase_nxt = r_phase;
    if (w_enter_own) begin
      w_frame_nxt = '0;
      w_phase_nxt = 1'b1;
    end else if (w_frame_adv) begin
      if (r_frame == FRAME_LAST) begin
        w_frame_nxt = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_frame_nxt = r_frame + FW'(1);
      end
    end
  end

  // Output logic: computed from next-state values so the registered outputs
  // always agree with the state and digit held in the same cycle.
  always_comb begin
    w_grant_nxt = 4'b0000;
    w_an_nxt    = 4'b0000;
    w_seg_nxt   = 7'b0000000;
    w_src       = idle_num;
    w_nib       = 4'h0;
    if (w_state_nxt == S_OWN) begin
      w_grant_nxt = 4'b0001 << w_owner_nxt;
      w_src       = num_bus[{w_owner_nxt, 4'b0000} +: 16];
    end
    if (w_state_nxt != S_GAP) begin
      w_nib     = w_src[{w_digit_nxt, 2'b00} +: 4];
      w_an_nxt  = 4'b0001 << w_digit_nxt;
      w_seg_nxt = f_decode(w_nib);
      if (w_state_nxt == S_OWN && !w_phase_nxt && blink_bus[{w_owner_nxt, w_digit_nxt}])
        w_seg_nxt = 7'b0000000;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_slot  <= '0;
      r_digit <= 2'd3;
      r_frame <= '0;
      r_phase <= 1'b1;
      r_grant <= 4'b0000;
      r_an    <= 4'b1000;
      r_seg   <= 7'b0000000;
    end else begin
      r_slot  <= w_slot_nxt;
      r_digit <= w_digit_nxt;
      r_frame <= w_frame_nxt;
      r_phase <= w_phase_nxt;
      r_grant <= w_grant_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign grant = r_grant;
  assign an    = r_an;
  assign seg   = r_seg;

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - self-checking bench for display_arbiter
module tb_display_arbiter;

  localparam int SD = 4;
  localparam int BH = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] num_bus = 64'h0;
  logic [15:0] blink_bus = 16'h0;
  logic [15:0] idle_num = 16'h0;
  logic [3:0]  grant;
  logic [3:0]  an;
  logic [6:0]  seg;

  display_arbiter #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
    .clk(clk), .resetn(resetn), .req(req), .num_bus(num_bus),
    .blink_bus(blink_bus), .idle_num(idle_num),
    .grant(grant), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};

  // Reference model: mode 0 idle, 1 gap, 2 own; time measured in edges since reset.
  int m_mode, m_owner, m_pend, m_tick, m_start;
  bit m_pv;
  logic [3:0] e_grant, e_an;
  logic [6:0] e_seg;

  function automatic int pick(input logic [3:0] r);
    int order [4] = '{0, 3, 2, 1};
    for (int k = 0; k < 4; k++) if (r[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      if (failures <= 40) $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_pend = 0; m_pv = 0; m_tick = 0; m_start = 0;
  endtask

  task automatic model_out();
    int d, n;
    logic [15:0] src;
    logic [3:0] nib;
    e_grant = (m_mode == 2) ? 4'(1 << m_owner) : 4'b0000;
    if (m_mode == 1) begin
      e_an = 4'b0000;
      e_seg = 7'b0;
    end else begin
      d = 3 - ((m_tick / SD) % 4);
      src = (m_mode == 2) ? num_bus[16*m_owner +: 16] : idle_num;
      nib = src[4*d +: 4];
      e_an = 4'(1 << d);
      e_seg = seg_tab[nib];
      if (m_mode == 2) begin
        n = (m_tick / FR) - (m_start / FR);
        if (((n / BH) % 2) == 1 && blink_bus[4*m_owner + d]) e_seg = 7'b0;
      end
    end
  endtask

  task automatic model_edge();
    int p;
    p = pick(req);
    case (m_mode)
      0: if (p >= 0) begin m_mode = 1; m_pend = p; m_pv = 1; end
      1: if (m_pv && req[m_pend]) begin
           m_mode = 2; m_owner = m_pend; m_start = m_tick + 1;
         end else begin
           m_mode = 0; m_pv = 0;
         end
      default: if (!req[m_owner]) begin
                 m_mode = 1; m_pv = (p >= 0); m_pend = (p >= 0) ? p : 0;
               end else if (m_owner != 0 && req[0]) begin
                 m_mode = 1; m_pend = 0; m_pv = 1;
               end
    endcase
    m_tick++;
    model_out();
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant", {3'b0, grant}, {3'b0, e_grant});
    chk("an", {3'b0, an}, {3'b0, e_an});
    chk("seg", seg, e_seg);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int blank_low, blank_high;

  initial begin
    model_reset();
    idle_num = 16'h1234;
    #1 resetn = 1'b1;
    #1;
    chk("rst_grant", {3'b0, grant}, 7'b0);
    chk("rst_an", {3'b0, an}, 7'b0001000);
    chk("rst_seg", seg, 7'b0);
    @(negedge clk);
    resetn = 1'b0;
    model_reset();

    // Idle scan of 1234
    cycle();
    chk("idle_d3_an", {3'b0, an}, 7'b0001000);
    chk("idle_d3_seg", seg, 7'b0000110);
    run(15);

    // Grant latency to service 2
    num_bus[47:32] = 16'h0759;
    req = 4'b0100;
    cycle();
    chk("gap_grant", {3'b0, grant}, 7'b0);
    chk("gap_an", {3'b0, an}, 7'b0);
    chk("gap_seg", seg, 7'b0);
    cycle();
    chk("own2_grant", {3'b0, grant}, 7'b0000100);
    run(16);

    // Handover to service 1, no preemption by service 2, preemption by service 4
    num_bus[63:48] = 16'h8642;
    req = 4'b1000;
    run(6);
    req = 4'b1100;
    run(8);
    chk("no_preempt", {3'b0, grant}, 7'b0001000);
    num_bus[15:0] = 16'h4321;
    req = 4'b1101;
    cycle();
    chk("pre_gap", {3'b0, grant}, 7'b0);
    cycle();
    chk("pre_own4", {3'b0, grant}, 7'b0000001);
    run(6);
    req = 4'b1100;
    cycle();
    chk("ret_gap", {3'b0, grant}, 7'b0);
    cycle();
    chk("ret_own1", {3'b0, grant}, 7'b0001000);
    run(4);

    // Blink on service 2 with mask 0011
    blink_bus[11:8] = 4'b0011;
    req = 4'b0100;
    blank_low = 0;
    blank_high = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      if (seg == 7'b0 && (an == 4'b0010 || an == 4'b0001)) blank_low++;
      if (seg == 7'b0 && (an == 4'b1000 || an == 4'b0100)) blank_high++;
    end
    chk("blink_seen", 7'(blank_low > 0), 7'd1);
    chk("blink_hi_never", 7'(blank_high), 7'd0);

    // Invalid BCD digits
    blink_bus = 16'h0;
    num_bus[47:32] = 16'hA9F0;
    run(16);

    // Asynchronous reset mid-slot while owned
    @(posedge clk);
    model_edge();
    #3 resetn = 1'b1;
    #1;
    chk("arst_grant", {3'b0, grant}, 7'b0);
    chk("arst_an", {3'b0, an}, 7'b0001000);
    chk("arst_seg", seg, 7'b0);
    req = 4'b0000;
    idle_num = 16'h5678;
    model_reset();
    #1 resetn = 1'b0;
    cycle();
    chk("arst_d3_seg", seg, 7'b1101101);
    run(8);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        req[b] = ~req[b];
      end
      if ($urandom_range(0, 20) == 0) num_bus = {$urandom, $urandom};
      if ($urandom_range(0, 40) == 0) blink_bus = 16'($urandom);
      if ($urandom_range(0, 40) == 0) idle_num = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
